lzd_norm_pipe: RTL and testbench
================================

// Module: lzd_norm_pipe
// PURPOSE
//   Pipelined leading-zero/leading-one detector and normaliser for the FP datapath.
//   Each accepted word produces its leading-digit count and the word shifted left
//   by that count. A valid/ready handshake with full-pipeline stall allows it to sit
//   between the adder back-end and the rounding stage. Generalises the combinational
//   lzd with depth, mode and flow control.
// PARAMETERS
//   WIDTH    64  data width; power of 2, >= 4
//   LATENCY  2   register stages from accept to out_valid; legal 1..3
// PORTS
//   clk        in   1                clock, all state on posedge
//   reset      in   1                synchronous, active-high
//   in_valid   in   1                in_data/in_mode are valid
//   in_ready   out  1                block accepts on in_valid & in_ready
//   in_data    in   WIDTH            word to count/normalise
//   in_mode    in   1                0 = count leading zeros, 1 = count leading ones
//   out_valid  out  1                result valid
//   out_ready  in   1                consumer takes result on out_valid & out_ready
//   out_data   out  WIDTH            in_data << out_zp, zero fill
//   out_zp     out  $clog2(WIDTH)    leading-digit count (0..WIDTH-1)
//   out_zv     out  1                1 = terminating digit found (word not all 0s/1s)
// BEHAVIOUR
// - Reset, sampled on posedge: all stage valid bits <= 0.
//   - out_valid = 0, out_data = 0, out_zp = 0, out_zv = 0 the cycle after reset is seen.
//   - in_ready = 0 while reset is high; inputs are ignored.
// - Reset mid-operation flushes every in-flight word. Nothing is emitted afterwards.
// - Pipeline: LATENCY stages, each with a valid bit and payload.
//   - advance = ~last_valid | out_ready; in_ready = advance & ~reset.
//   - When advance = 1, every stage shifts forward by one. Stage0 loads in_valid & in_ready.
//   - When advance = 0, all stages hold.
//   - Bubbles are not collapsed. Order is strictly FIFO. No drop, no duplicate.
// - Latency: with out_ready held high, a word accepted at edge N shows out_valid = 1
//   after edge N+LATENCY-1 (LATENCY=1: output registered at the accept edge).
//   Throughput is 1 word/cycle.
// - Stage split:
//   - LATENCY = 1: detect and shift in one stage.
//   - LATENCY = 2: stage0 registers data/mode and count; stage1 registers the shift.
//   - LATENCY = 3: the count is split into upper- and lower-half LZD plus merge,
//     then shift.
// - Count rule. Mode 0: zp = number of zeros above the MSB-most 1. Mode 1: same with
//   0 and 1 swapped.
// - Boundary: in_data all zeros (mode 0) or all ones (mode 1):
//   - out_zv = 0, out_zp = 0, out_data = in_data unchanged.
// - Boundary: MSB already terminates (bit WIDTH-1 = 1 in mode 0, = 0 in mode 1):
//   - out_zv = 1, out_zp = 0, out_data = in_data.
// - Outputs are stable while out_valid & ~out_ready, and hold their last value while
//   out_valid = 0.
// - in_mode travels with its word. Mode may change every accepted word.
// TESTING (WIDTH=64, LATENCY=2 unless stated)
// 1. Mode 0, 0x0000_0000_0000_0001, out_ready=1 -> 2 cycles later out_zp=63, out_zv=1,
//    out_data=0x8000_0000_0000_0000.
// 2. Mode 0, 0x0; then mode 1, 0xFFFF_FFFF_FFFF_FFFF -> both give out_zv=0, out_zp=0,
//    out_data equal to input. Mode 0, 0x8000_0000_0000_0000 -> zp=0, zv=1, unchanged.
// 3. Mode 1, 0xFFF0_0000_0000_1234 -> out_zp=12, out_zv=1,
//    out_data=0x0000_0000_0123_4000.
// 4. Back-to-back words 1,2,4,8 (mode 0) with out_ready=0 for 3 cycles at first
//    out_valid:
//    - in_ready drops while the pipe is full; outputs hold.
//    - Results zp = 63,62,61,60 arrive in order, none lost or repeated.
// 5. reset pulsed for 1 cycle with 2 words in flight -> out_valid=0 the next cycle and
//    neither word appears. The next word (0x00FF_0000_0000_0000) gives zp=8, latency 2.
// 6. LATENCY = 1, 2 and 3, 256 $random words with random mode and random out_ready ->
//    compare against a behavioural model; latency equals LATENCY with no stall.

Source files
------------

// File: rtl/lzd_norm_pipe.sv
// Pipelined leading-zero / leading-one detector and normaliser.
// Each accepted word yields its leading-digit count (out_zp), a flag telling
// whether a terminating digit exists (out_zv), and the word shifted left by
// the count. The whole pipe advances together under a valid/ready handshake;
// when the output is held, every stage holds with it.
module lzd_norm_pipe #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_zp,
    output logic                     out_zv
);

    localparam int ZW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;

    // Leading-one counting reduces to leading-zero counting on the inverted word.
    function automatic logic [WIDTH-1:0] fold_mode(input logic [WIDTH-1:0] x, input logic m);
        return m ? ~x : x;
    endfunction

    // Leading-zero count of the full word; an all-zero word returns 0.
    function automatic logic [ZW-1:0] lzc_full(input logic [WIDTH-1:0] x);
        logic [ZW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) c = ZW'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    // Leading-zero count of a half word; an all-zero half returns 0.
    function automatic logic [ZW-2:0] lzc_half(input logic [HW-1:0] x);
        logic [ZW-2:0] c;
        c = '0;
        for (int i = 0; i < HW; i++) begin
            if (x[i]) c = (ZW-1)'(HW - 1 - i);
        end
        return c;
    endfunction

    // Normalising shift with zero fill; a zero count leaves the word unchanged.
    function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] x,
                                                    input logic [ZW-1:0]    sh);
        return x << sh;
    endfunction

    logic             advance;
    logic             accept;
    logic             vld_last_q;
    logic             last_in_vld;
    logic [WIDTH-1:0] last_data_d;
    logic [ZW-1:0]    last_zp_d;
    logic             last_zv_d;
    logic [WIDTH-1:0] out_data_q;
    logic [ZW-1:0]    out_zp_q;
    logic             out_zv_q;

    // The pipe only moves when the output slot is empty or being drained.
    assign advance  = ~vld_last_q | out_ready;
    assign in_ready = advance & ~reset;
    assign accept   = in_valid & in_ready;

    generate
        if (LATENCY == 1) begin : g_lat1
            logic [WIDTH-1:0] fold_p0;
            logic [ZW-1:0]    zp_p0;
            logic             zv_p0;

            // ---- stage 0 (only stage): detect and shift straight from the input ----
            // Count the leading digits of the incoming word.
            always_comb begin
                fold_p0 = fold_mode(in_data, in_mode);
                zv_p0   = |fold_p0;
                zp_p0   = zv_p0 ? lzc_full(fold_p0) : '0;
            end

            assign last_in_vld = accept;
            assign last_data_d = norm_shift(in_data, zp_p0);
            assign last_zp_d   = zp_p0;
            assign last_zv_d   = zv_p0;

        end else if (LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] fold_in;
            logic [ZW-1:0]    zp_in;
            logic             zv_in;
            logic             vld_p0_q;
            logic [WIDTH-1:0] data_p0_q;
            logic [ZW-1:0]    zp_p0_q;
            logic             zv_p0_q;

            // Count the leading digits of the incoming word.
            always_comb begin
                fold_in = fold_mode(in_data, in_mode);
                zv_in   = |fold_in;
                zp_in   = zv_in ? lzc_full(fold_in) : '0;
            end

            // ---- stage 0: register word and count ----
            // Stage-0 valid bit moves with the pipe; cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p0_q <= 1'b0;
                end else if (advance) begin
                    vld_p0_q <= accept;
                end
            end

            // Stage-0 payload is captured only for accepted words.
            always_ff @(posedge clk) begin
                if (advance && accept) begin
                    data_p0_q <= in_data;
                    zp_p0_q   <= zp_in;
                    zv_p0_q   <= zv_in;
                end
            end

            // ---- stage 1: shift into the output register ----
            assign last_in_vld = vld_p0_q;
            assign last_data_d = norm_shift(data_p0_q, zp_p0_q);
            assign last_zp_d   = zp_p0_q;
            assign last_zv_d   = zv_p0_q;

        end else begin : g_lat3
            logic [WIDTH-1:0] fold_in;
            logic             vld_p0_q;
            logic [WIDTH-1:0] data_p0_q;
            logic [ZW-2:0]    up_cnt_p0_q;
            logic             up_any_p0_q;
            logic [ZW-2:0]    lo_cnt_p0_q;
            logic             lo_any_p0_q;
            logic [ZW-1:0]    zp_mrg;
            logic             zv_mrg;
            logic             vld_p1_q;
            logic [WIDTH-1:0] data_p1_q;
            logic [ZW-1:0]    zp_p1_q;
            logic             zv_p1_q;

            assign fold_in = fold_mode(in_data, in_mode);

            // ---- stage 0: independent upper/lower half counts ----
            // Stage-0 and stage-1 valid bits move with the pipe; cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p0_q <= 1'b0;
                    vld_p1_q <= 1'b0;
                end else if (advance) begin
                    vld_p0_q <= accept;
                    vld_p1_q <= vld_p0_q;
                end
            end

            // Stage-0 payload: raw word plus the two half-word counts.
            always_ff @(posedge clk) begin
                if (advance && accept) begin
                    data_p0_q   <= in_data;
                    up_cnt_p0_q <= lzc_half(fold_in[WIDTH-1:HW]);
                    up_any_p0_q <= |fold_in[WIDTH-1:HW];
                    lo_cnt_p0_q <= lzc_half(fold_in[HW-1:0]);
                    lo_any_p0_q <= |fold_in[HW-1:0];
                end
            end

            // ---- stage 1: merge half counts ----
            // A hit in the upper half wins; otherwise the lower count is offset by HW.
            always_comb begin
                zv_mrg = up_any_p0_q | lo_any_p0_q;
                zp_mrg = '0;
                if (up_any_p0_q) begin
                    zp_mrg = {1'b0, up_cnt_p0_q};
                end else if (lo_any_p0_q) begin
                    zp_mrg = {1'b1, lo_cnt_p0_q};
                end
            end

            // Stage-1 payload: word with its merged count.
            always_ff @(posedge clk) begin
                if (advance && vld_p0_q) begin
                    data_p1_q <= data_p0_q;
                    zp_p1_q   <= zp_mrg;
                    zv_p1_q   <= zv_mrg;
                end
            end

            // ---- stage 2: shift into the output register ----
            assign last_in_vld = vld_p1_q;
            assign last_data_d = norm_shift(data_p1_q, zp_p1_q);
            assign last_zp_d   = zp_p1_q;
            assign last_zv_d   = zv_p1_q;
        end
    endgenerate

    // Output stage: cleared on reset, loads only real words so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_last_q <= 1'b0;
            out_data_q <= '0;
            out_zp_q   <= '0;
            out_zv_q   <= 1'b0;
        end else if (advance) begin
            vld_last_q <= last_in_vld;
            if (last_in_vld) begin
                out_data_q <= last_data_d;
                out_zp_q   <= last_zp_d;
                out_zv_q   <= last_zv_d;
            end
        end
    end

    assign out_valid = vld_last_q;
    assign out_data  = out_data_q;
    assign out_zp    = out_zp_q;
    assign out_zv    = out_zv_q;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: directed table, stall/flush sequences and a
// randomized run per LATENCY against a behavioural scoreboard model.
module tb_lzd_norm_pipe;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  zp;
        logic        zv;
    } res_t;

    typedef struct {
        logic        mode;
        logic [63:0] din;
        logic [63:0] dout;
        logic [5:0]  zp;
        logic        zv;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [63:0] in_data   [3];
    logic        in_mode   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [63:0] out_data  [3];
    logic [5:0]  out_zp    [3];
    logic        out_zv    [3];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   act = 1;
    int   pushed = 0;
    bit   lat_chk = 0;
    res_t exp_q[$];
    int   acc_q[$];
    res_t mon_r;
    int   mon_a;
    vec_t tbl [10];

    // Instance g has LATENCY g+1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        lzd_norm_pipe #(.WIDTH(64), .LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_zp    (out_zp[g]),
            .out_zv    (out_zv[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Reference: count digits equal to the mode bit from the MSB down.
    function automatic res_t ref_nrm(input logic [63:0] d, input logic m);
        res_t r;
        int   n;
        n = 0;
        while (n < 64 && d[63-n] == m) n++;
        if (n == 64) begin
            r.data = d; r.zp = 6'd0; r.zv = 1'b0;
        end else begin
            r.data = d << n; r.zp = 6'(n); r.zv = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns just after the accept edge.
    task automatic send(input int k, input logic m, input logic [63:0] d);
        int t;
        in_valid[k] = 1'b1;
        in_mode[k]  = m;
        in_data[k]  = d;
        #1;
        t = 0;
        while (!in_ready[k] && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) chk("send_timeout", 1, 0);
        tick();
        in_valid[k] = 1'b0;
    endtask

    // Wait for out_valid; returns the number of extra edges waited.
    task automatic wait_out(input int k, output int cnt);
        cnt = 0;
        while (!out_valid[k] && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] d;
        int          sel;
        d   = {$urandom, $urandom};
        sel = $urandom_range(0, 9);
        if (sel == 0) d = '0;
        else if (sel == 1) d = '1;
        else begin
            d = d >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) d = ~d;
        end
        return d;
    endfunction

    // Scoreboard: record accepted words, compare every word the consumer takes.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid[act] && out_ready[act]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_r = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    chk("model", {out_data[act], out_zp[act], out_zv[act]}, mon_r);
                    if (lat_chk) chk("latency", cyc - mon_a, act);
                end
            end
            if (in_valid[act] && in_ready[act]) begin
                exp_q.push_back(ref_nrm(in_data[act], in_mode[act]));
                acc_q.push_back(cyc + 1);
                pushed++;
            end
        end
    end

    initial begin
        int cnt;
        int t;
        int wi;
        int got;
        int stall;
        bit seen;

        tbl[0] = '{1'b0, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 6'd63, 1'b1};
        tbl[1] = '{1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 6'd0,  1'b0};
        tbl[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0,  1'b0};
        tbl[3] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd0,  1'b1};
        tbl[4] = '{1'b1, 64'hFFF0_0000_0000_1234, 64'h0000_0000_0123_4000, 6'd12, 1'b1};
        tbl[5] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 6'd0,  1'b1};
        tbl[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0000, 6'd63, 1'b1};
        tbl[7] = '{1'b0, 64'h00FF_0000_0000_0000, 64'hFF00_0000_0000_0000, 6'd8,  1'b1};
        tbl[8] = '{1'b0, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 6'd31, 1'b1};
        tbl[9] = '{1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 6'd0,  1'b1};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_mode[k]   = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) tick();

        // Reset state on every instance.
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", in_ready[k], 0);
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_out_data", out_data[k], 0);
            chk("rst_out_zp", out_zp[k], 0);
            chk("rst_out_zv", out_zv[k], 0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready[1], 1);

        // Directed table on the LATENCY=2 instance.
        act = 1;
        for (int i = 0; i < 10; i++) begin
            send(1, tbl[i].mode, tbl[i].din);
            wait_out(1, cnt);
            chk("tbl_latency", cnt, 1);
            chk("tbl_data", out_data[1], tbl[i].dout);
            chk("tbl_zp", out_zp[1], tbl[i].zp);
            chk("tbl_zv", out_zv[1], tbl[i].zv);
            tick();
        end

        // Back-to-back 1,2,4,8 with a 3-cycle output stall at first out_valid.
        wi = 0; got = 0; stall = 0; seen = 0; t = 0;
        while (got < 4 && t < 40) begin
            in_valid[1] = (wi < 4);
            in_mode[1]  = 1'b0;
            in_data[1]  = 64'h1 << wi;
            if (out_valid[1] && !seen) begin
                seen  = 1;
                stall = 3;
            end
            out_ready[1] = (stall == 0);
            #1;
            if (stall > 0) begin
                chk("stall_in_ready", in_ready[1], 0);
                chk("stall_hold_zp", out_zp[1], 6'd63);
                chk("stall_hold_data", out_data[1], 64'h8000_0000_0000_0000);
                stall--;
            end
            if (out_valid[1] && out_ready[1]) begin
                chk("b2b_zp", out_zp[1], 63 - got);
                got++;
            end
            if (in_valid[1] && in_ready[1]) wi++;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        chk("b2b_count", got, 4);
        chk("b2b_sent", wi, 4);
        cnt = 0;
        repeat (4) begin
            tick();
            if (out_valid[1]) cnt++;
        end
        chk("b2b_no_dup", cnt, 0);

        // Reset with two words in flight flushes both.
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_mode[1]   = 1'b0;
        in_data[1]   = 64'h0000_0000_0000_0010;
        tick();
        in_data[1]   = 64'h0000_0000_0000_0020;
        tick();
        chk("flush_full", out_valid[1], 1);
        in_valid[1] = 1'b0;
        reset       = 1'b1;
        tick();
        chk("flush_in_ready", in_ready[1], 0);
        chk("flush_out_valid", out_valid[1], 0);
        chk("flush_out_data", out_data[1], 0);
        chk("flush_out_zp", out_zp[1], 0);
        chk("flush_out_zv", out_zv[1], 0);
        reset        = 1'b0;
        out_ready[1] = 1'b1;
        cnt = 0;
        repeat (4) begin
            tick();
            if (out_valid[1]) cnt++;
        end
        chk("flush_nothing_out", cnt, 0);
        send(1, 1'b0, 64'h00FF_0000_0000_0000);
        wait_out(1, cnt);
        chk("flush_next_latency", cnt, 1);
        chk("flush_next_zp", out_zp[1], 8);
        chk("flush_next_zv", out_zv[1], 1);
        tick();

        // Randomized run per LATENCY: stalled phase, drain, then stall-free phase.
        for (int k = 0; k < 3; k++) begin
            act   = k;
            reset = 1'b1;
            repeat (2) tick();
            reset  = 1'b0;
            pushed = 0;
            t = 0;
            while (pushed < 150 && t < 5000) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_mode[k]   = 1'($urandom_range(0, 1));
                in_data[k]   = rand_word();
                out_ready[k] = ($urandom_range(0, 3) != 0);
                tick();
                t++;
            end
            chk("rand_a_sent", pushed, 150);
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                tick();
                t++;
            end
            chk("rand_a_drain", exp_q.size(), 0);
            lat_chk = 1;
            t = 0;
            while (pushed < 256 && t < 5000) begin
                in_valid[k] = ($urandom_range(0, 3) != 0);
                in_mode[k]  = 1'($urandom_range(0, 1));
                in_data[k]  = rand_word();
                tick();
                t++;
            end
            chk("rand_b_sent", pushed, 256);
            in_valid[k] = 1'b0;
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                tick();
                t++;
            end
            chk("rand_b_drain", exp_q.size(), 0);
            lat_chk = 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
